// File: rtl/mips_boot_ctrl_if.sv
// Bus bundle between the host loader, mips_boot_ctrl and the instruction memory / core.
// Carries the host stream (in_valid/in_data/in_ready), the imem write port and core status.
// slave: the boot controller's view. master: the host/harness view (drives the stream, observes the rest).
interface mips_boot_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/mips_boot_ctrl.sv
// Boot controller: loads a length-prefixed program into imem, then releases the mips core from reset.
// Latency: an accepted word is written one cycle later; the core is released HOLD_CYCLES+1 cycles after the final accept.
// Backpressure: in_ready is decoded from the registered state (LEN/LOAD/CHECK only); it never depends on in_valid.
// Ports: clock, reset (async, active-high); bus (slave modport) carrying the host stream, imem write port,
//   cpu_reset, done and the sticky error flag.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing 32-bit wrapping-sum word after the payload.
module mips_boot_ctrl #(
  parameter int WORDS       = 64,
  parameter int ADDR_W      = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  mips_boot_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
`endif
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_CYCLES);

  logic [2:0]        state_q, state_d;
  // One bit wider than the address so N = WORDS = 2**ADDR_W is representable.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        hold_q, hold_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic accept;
  logic len_ok;
  logic last_word;

  // Length is range-checked on the full 32-bit word so out-of-range values never alias into range.
  assign len_ok    = (bus.in_data != 32'd0) && (bus.in_data <= 32'(WORDS));
  assign last_word = (cnt_q == (len_q - CNT_ONE));
  assign accept    = bus.in_valid && bus.in_ready;

`ifdef BOOT_CHECKSUM_EN
  assign bus.in_ready = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHECK);
`else
  assign bus.in_ready = (state_q == S_LEN) || (state_q == S_LOAD);
`endif
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_reset  = (state_q != S_RUN);
  assign bus.done       = (state_q == S_RUN);
  assign bus.error      = (state_q == S_ERROR);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    hold_d       = hold_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_LEN;
      S_LEN: begin
`ifdef BOOT_CHECKSUM_EN
        sum_d = 32'd0;
`endif
        if (accept) begin
          if (len_ok) begin
            len_d   = bus.in_data[ADDR_W:0];
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = cnt_q[ADDR_W-1:0];
          imem_wdata_d = bus.in_data;
          cnt_d        = cnt_q + CNT_ONE;
`ifdef BOOT_CHECKSUM_EN
          sum_d        = sum_q + bus.in_data;
          if (last_word) state_d = S_CHECK;
`else
          if (last_word) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (bus.in_data == sum_q) begin
            state_d = S_HOLD;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
`endif
      // The counter is loaded on the entry edge and counts down to zero before release,
      // so HOLD occupies HOLD_CYCLES+1 cycles and the core sees the full write plus settle time.
      S_HOLD: begin
        if (hold_q == 8'd0) state_d = S_RUN;
        else                hold_d  = hold_q - 8'd1;
      end
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      hold_q       <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Self-checking bench for mips_boot_ctrl (WORDS=64, ADDR_W=6, HOLD_CYCLES=4).
// A stream-level model predicts every output each cycle; directed tests add literal expectations.
module tb_mips_boot_ctrl;
  localparam int WORDS  = 64;
  localparam int ADDR_W = 6;
  localparam int HOLD   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mips_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  mips_boot_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60)
        $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stream-level model ----------------
  // Tracks words accepted since reset: word 0 is the length, words 1..N are payload,
  // (with checksum) word N+1 is the sum. Release follows HOLD+1 edges after the final accept.
  int              m_e     = 0;   // edges since reset release
  int              m_acc   = 0;   // words accepted
  logic [31:0]     m_n     = 0;
  bit              m_bad   = 0;
  bit              m_fin   = 0;
  int              m_fin_e = 0;
  bit              m_we    = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]     m_wdata = 0;
  logic [31:0]     m_sum   = 0;
  bit              m_take;

  function automatic bit m_ready();
    return (m_e >= 1) && !m_bad && !m_fin;
  endfunction

  function automatic bit m_done();
    return m_fin && (m_e >= m_fin_e + HOLD + 1);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_e = 0; m_acc = 0; m_n = 0; m_bad = 0; m_fin = 0; m_fin_e = 0;
      m_we = 0; m_addr = '0; m_wdata = 0; m_sum = 0;
    end else begin
      m_take = m_ready() && bus.in_valid;
      m_we = 0;
      if (m_take) begin
        if (m_acc == 0) begin
          m_n   = bus.in_data;
          m_bad = (m_n == 0) || (m_n > WORDS);
          m_sum = 0;
        end else if (32'(m_acc) <= m_n) begin
          m_we    = 1;
          m_addr  = ADDR_W'(m_acc - 1);
          m_wdata = bus.in_data;
          m_sum   = m_sum + bus.in_data;
`ifndef BOOT_CHECKSUM_EN
          if (32'(m_acc) == m_n) begin m_fin = 1; m_fin_e = m_e + 1; end
`endif
        end else begin
          if (bus.in_data == m_sum) begin m_fin = 1; m_fin_e = m_e + 1; end
          else m_bad = 1;
        end
        m_acc++;
      end
      m_e++;
    end
  end

  // ---------------- observation and per-cycle comparison ----------------
  int cyc = 0;
  int done_rise = -1;
  int last_acc = 0;
  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    cmp("in_ready",   bus.in_ready,   m_ready());
    cmp("imem_we",    bus.imem_we,    m_we);
    cmp("imem_addr",  bus.imem_addr,  m_addr);
    cmp("imem_wdata", bus.imem_wdata, m_wdata);
    cmp("cpu_reset",  bus.cpu_reset,  !m_done());
    cmp("done",       bus.done,       m_done());
    cmp("error",      bus.error,      m_bad);
    if (bus.imem_we === 1'b1) begin
      obs_addr.push_back(bus.imem_addr);
      obs_data.push_back(bus.imem_wdata);
    end
    if (bus.done === 1'b1 && done_rise < 0) done_rise = cyc;
  end

  // ---------------- stimulus ----------------
  logic [31:0] stream_q[$];

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    obs_addr.delete();
    obs_data.delete();
    done_rise = -1;
    reset = 1'b0;
  endtask

  task automatic add_cks();
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] s = 0;
    for (int i = 1; i < stream_q.size(); i++) s += stream_q[i];
    stream_q.push_back(s);
`endif
  endtask

  task automatic run_stream(input bit toggle);
    int i = 0;
    int guard = 0;
    bit phase = 1'b1;
    bit v;
    bit rdy;
    while (i < stream_q.size() && guard < 400) begin
      v = toggle ? phase : 1'b1;
      phase = ~phase;
      bus.in_valid = v;
      bus.in_data  = v ? stream_q[i] : 32'hDEADBEEF;
      @(negedge clock);
      rdy = bus.in_ready;
      @(posedge clock);
      #2;
      if (v && rdy) begin
        last_acc = cyc;
        i++;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    cmp("stream_accepted", i, stream_q.size());
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  logic [31:0] basic_dat[3];
  int bad_idx;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    basic_dat[0] = 32'h20080005;
    basic_dat[1] = 32'h21090003;
    basic_dat[2] = 32'h00000000;

    // Reset state.
    do_reset();
    cmp("rst_in_ready",  bus.in_ready,  0);
    cmp("rst_cpu_reset", bus.cpu_reset, 1);
    cmp("rst_done",      bus.done,      0);
    cmp("rst_error",     bus.error,     0);
    settle(1);
    cmp("len_in_ready",  bus.in_ready,  1);

    // Basic load with in_valid held high.
    do_reset();
    stream_q = '{32'd3, 32'h20080005, 32'h21090003, 32'h00000000};
    add_cks();
    run_stream(1'b0);
    settle(HOLD + 6);
    cmp("basic_nwrites", obs_addr.size(), 3);
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      cmp("basic_addr", obs_addr[i], i);
      cmp("basic_data", obs_data[i], basic_dat[i]);
    end
    cmp("basic_release_delay", done_rise - last_acc, 5);
    cmp("basic_done",      bus.done,      1);
    cmp("basic_cpu_reset", bus.cpu_reset, 0);
    cmp("basic_in_ready",  bus.in_ready,  0);

    // Backpressure: in_valid toggles every cycle.
    do_reset();
    stream_q = '{32'd4, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    add_cks();
    run_stream(1'b1);
    settle(HOLD + 6);
    cmp("bp_nwrites", obs_addr.size(), 4);
    bad_idx = 0;
    for (int i = 0; i < obs_addr.size(); i++)
      if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== 32'hA0 + i) bad_idx++;
    cmp("bp_order", bad_idx, 0);
    cmp("bp_done", bus.done, 1);

    // Bad length 0 and 65.
    do_reset();
    stream_q = '{32'd0};
    run_stream(1'b0);
    cmp("len0_error",     bus.error,     1);
    cmp("len0_cpu_reset", bus.cpu_reset, 1);
    cmp("len0_in_ready",  bus.in_ready,  0);
    settle(4);
    cmp("len0_nwrites",   obs_addr.size(), 0);

    do_reset();
    stream_q = '{32'd65};
    run_stream(1'b0);
    cmp("len65_error",    bus.error,    1);
    cmp("len65_in_ready", bus.in_ready, 0);
    settle(4);
    cmp("len65_nwrites",  obs_addr.size(), 0);
    cmp("len65_done",     bus.done,     0);

    // Reset mid-load, then a fresh N=2 load.
    do_reset();
    stream_q = '{32'd5, 32'h11, 32'h22};
    run_stream(1'b0);
    reset = 1'b1;
    #1;
    cmp("midrst_in_ready",  bus.in_ready,  0);
    cmp("midrst_imem_we",   bus.imem_we,   0);
    cmp("midrst_imem_addr", bus.imem_addr, 0);
    cmp("midrst_wdata",     bus.imem_wdata, 0);
    cmp("midrst_cpu_reset", bus.cpu_reset, 1);
    do_reset();
    stream_q = '{32'd2, 32'hB0, 32'hB1};
    add_cks();
    run_stream(1'b0);
    settle(HOLD + 6);
    cmp("reload_nwrites", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      cmp("reload_addr0", obs_addr[0], 0);
      cmp("reload_addr1", obs_addr[1], 1);
    end
    cmp("reload_done", bus.done, 1);

    // Maximum length N = WORDS.
    do_reset();
    stream_q = '{32'd64};
    for (int i = 0; i < WORDS; i++) stream_q.push_back(32'(i * 3 + 1));
    add_cks();
    run_stream(1'b0);
    settle(HOLD + 6);
    cmp("max_nwrites", obs_addr.size(), 64);
    if (obs_addr.size() == 64) begin
      cmp("max_last_addr", obs_addr[63], 63);
      cmp("max_last_data", obs_data[63], 32'd190);
    end
    bad_idx = 0;
    for (int i = 0; i < obs_addr.size(); i++)
      if (obs_addr[i] !== ADDR_W'(i)) bad_idx++;
    cmp("max_addr_seq", bad_idx, 0);
    cmp("max_done", bus.done, 1);

`ifdef BOOT_CHECKSUM_EN
    // Checksum accepted (0xFFFFFFFF + 2 wraps to 1) and rejected.
    do_reset();
    stream_q = '{32'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    run_stream(1'b0);
    settle(HOLD + 6);
    cmp("cks_ok_done",  bus.done,  1);
    cmp("cks_ok_error", bus.error, 0);

    do_reset();
    stream_q = '{32'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000002};
    run_stream(1'b0);
    settle(HOLD + 6);
    cmp("cks_bad_error",     bus.error,     1);
    cmp("cks_bad_cpu_reset", bus.cpu_reset, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
